// File: rtl/wm_cycle_ctrl.sv
// Washing-machine cycle controller: fill, heat, wash, drain, rinse, spin, done.
// Optional fill watchdog enabled by defining FILL_TIMEOUT_EN.
module wm_cycle_ctrl #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned WASH_CYCLES  = 1000,
    parameter int unsigned RINSE_CYCLES = 600,
    parameter int unsigned SPIN_CYCLES  = 400,
    parameter int unsigned FILL_TIMEOUT = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       cancel,
    input  logic       pause,
    input  logic       door_closed,
    input  logic       water_full,
    input  logic       water_empty,
    input  logic       temp_ok,
    output logic [2:0] state,
    output logic       door_lock,
    output logic       valve_in,
    output logic       drain_pump,
    output logic       heater,
    output logic       motor_wash,
    output logic       motor_spin,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic       fill_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b000,
        S_FILL  = 3'b001,
        S_HEAT  = 3'b010,
        S_WASH  = 3'b011,
        S_DRAIN = 3'b100,
        S_RINSE = 3'b101,
        S_SPIN  = 3'b110,
        S_DONE  = 3'b111
    } state_e;

    localparam logic [CNT_W-1:0] WASH_LAST  = CNT_W'(WASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] RINSE_LAST = CNT_W'(RINSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             aborted_q, aborted_d;
    logic             fill_err_q, fill_err_d;

    logic             active;
    logic             hold;
    logic             run_timer;
    logic [CNT_W-1:0] phase_last;
    logic             at_last;

    assign active = (state_q != S_IDLE) && (state_q != S_DONE);
    assign hold   = active && (pause || !door_closed);

    // One shared terminal-count compare, selected by the phase being timed.
    always_comb begin
        phase_last = '0;
        run_timer  = 1'b0;
        case (state_q)
            S_WASH:  begin phase_last = WASH_LAST;  run_timer = 1'b1; end
            S_RINSE: begin phase_last = RINSE_LAST; run_timer = 1'b1; end
            S_SPIN:  begin phase_last = SPIN_LAST;  run_timer = 1'b1; end
            S_FILL: begin
                phase_last = FILL_LAST;
`ifdef FILL_TIMEOUT_EN
                run_timer  = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    assign at_last = (timer_q == phase_last);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        aborted_d  = aborted_q;
        fill_err_d = fill_err_q;

        if (cancel && (state_q inside {S_FILL, S_HEAT, S_WASH, S_RINSE})) begin
            state_d   = S_DRAIN;
            aborted_d = 1'b1;
        end else if (cancel && (state_q == S_DRAIN)) begin
            aborted_d = 1'b1;
        end else if (!hold) begin
            case (state_q)
                S_IDLE: if (start && door_closed) begin
                    state_d    = S_FILL;
                    aborted_d  = 1'b0;
                    fill_err_d = 1'b0;
                end
                S_FILL: begin
                    if (water_full) begin
                        state_d = S_HEAT;
                    end
`ifdef FILL_TIMEOUT_EN
                    else if (at_last) begin
                        state_d    = S_DRAIN;
                        aborted_d  = 1'b1;
                        fill_err_d = 1'b1;
                    end
`endif
                end
                S_HEAT:  if (temp_ok) state_d = S_WASH;
                S_WASH:  if (at_last) state_d = S_DRAIN;
                S_DRAIN: if (water_empty) state_d = aborted_q ? S_DONE : S_RINSE;
                S_RINSE: if (at_last) state_d = S_SPIN;
                S_SPIN:  if (at_last) state_d = S_DONE;
                S_DONE:  if (!door_closed) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (!hold && run_timer) begin
            timer_d = timer_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            aborted_q  <= 1'b0;
            fill_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            aborted_q  <= aborted_d;
            fill_err_q <= fill_err_d;
        end
    end

    always_comb begin
        valve_in   = 1'b0;
        drain_pump = 1'b0;
        heater     = 1'b0;
        motor_wash = 1'b0;
        motor_spin = 1'b0;
        if (!hold) begin
            case (state_q)
                S_FILL:  valve_in = 1'b1;
                S_HEAT:  heater = 1'b1;
                S_WASH:  motor_wash = 1'b1;
                S_DRAIN: drain_pump = 1'b1;
                S_RINSE: begin valve_in = 1'b1;   motor_wash = 1'b1; end
                S_SPIN:  begin drain_pump = 1'b1; motor_spin = 1'b1; end
                default: ;
            endcase
        end
    end

    assign state     = state_q;
    assign door_lock = active;
    assign busy      = active;
    assign done      = (state_q == S_DONE);
    assign aborted   = aborted_q;
`ifdef FILL_TIMEOUT_EN
    assign fill_err  = fill_err_q;
`else
    assign fill_err  = 1'b0;
`endif

endmodule

// File: tb/tb_wm_cycle_ctrl.sv
// Scoreboard bench for wm_cycle_ctrl: per-cycle expected state/outputs queued by the driver.
module tb_wm_cycle_ctrl;

    localparam logic [2:0] IDLE = 3'd0, FILL = 3'd1, HEAT = 3'd2, WASH = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4, RINSE = 3'd5, SPIN = 3'd6, DONE = 3'd7;

    logic clk = 1'b0;
    logic reset, start, cancel, pause, door_closed, water_full, water_empty, temp_ok;
    logic [2:0] state;
    logic door_lock, valve_in, drain_pump, heater, motor_wash, motor_spin;
    logic busy, done, aborted, fill_err;

    typedef struct {
        logic [2:0] st;
        logic [9:0] o;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   row_n    = 0;

    always #5 clk = ~clk;

    wm_cycle_ctrl #(
        .CNT_W        (16),
        .WASH_CYCLES  (4),
        .RINSE_CYCLES (3),
        .SPIN_CYCLES  (2),
        .FILL_TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .cancel      (cancel),
        .pause       (pause),
        .door_closed (door_closed),
        .water_full  (water_full),
        .water_empty (water_empty),
        .temp_ok     (temp_ok),
        .state       (state),
        .door_lock   (door_lock),
        .valve_in    (valve_in),
        .drain_pump  (drain_pump),
        .heater      (heater),
        .motor_wash  (motor_wash),
        .motor_spin  (motor_spin),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .fill_err    (fill_err)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // {door_lock, valve_in, drain_pump, heater, motor_wash, motor_spin, busy, done, aborted, fill_err}
    function automatic logic [9:0] exp_outs(input logic [2:0] st, input logic h,
                                            input logic ab, input logic fe);
        logic [4:0] act;
        logic       act_st;
        case (st)
            FILL:    act = 5'b10000;
            HEAT:    act = 5'b00100;
            WASH:    act = 5'b00010;
            DRAIN:   act = 5'b01000;
            RINSE:   act = 5'b10010;
            SPIN:    act = 5'b01001;
            default: act = 5'b00000;
        endcase
        act_st = (st != IDLE) && (st != DONE);
        if (h) act = 5'b00000;
        return {act_st, act, act_st, st == DONE, ab, fe};
    endfunction

    // Queue the expectation for the next rising edge, then advance to the following negedge.
    task automatic row(input logic [2:0] st, input logic h, input logic ab, input logic fe);
        exp_t e;
        e.st = st;
        e.o  = exp_outs(st, h, ab, fe);
        q.push_back(e);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            row_n++;
            check($sformatf("state r%0d", row_n), {13'd0, state}, {13'd0, e.st});
            check($sformatf("outs r%0d", row_n),
                  {6'd0, door_lock, valve_in, drain_pump, heater, motor_wash, motor_spin,
                   busy, done, aborted, fill_err},
                  {6'd0, e.o});
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; cancel = 1'b0; pause = 1'b0;
        door_closed = 1'b1; water_full = 1'b0; water_empty = 1'b0; temp_ok = 1'b0;
        @(negedge clk);
        row(IDLE, 0, 0, 0);
        row(IDLE, 0, 0, 0);

        // Normal programme 4/3/2
        reset = 1'b0; start = 1'b1;
        row(FILL, 0, 0, 0);
        start = 1'b0;
        repeat (4) row(FILL, 0, 0, 0);
        water_full = 1'b1; row(HEAT, 0, 0, 0);
        water_full = 1'b0; repeat (2) row(HEAT, 0, 0, 0);
        temp_ok = 1'b1; row(WASH, 0, 0, 0);
        temp_ok = 1'b0; repeat (3) row(WASH, 0, 0, 0);
        row(DRAIN, 0, 0, 0);
        row(DRAIN, 0, 0, 0);
        water_empty = 1'b1; row(RINSE, 0, 0, 0);
        water_empty = 1'b0; repeat (2) row(RINSE, 0, 0, 0);
        repeat (2) row(SPIN, 0, 0, 0);
        repeat (2) row(DONE, 0, 0, 0);
        door_closed = 1'b0; row(IDLE, 0, 0, 0);
        door_closed = 1'b1; row(IDLE, 0, 0, 0);

        // Pause in WASH at timer 2, then cancel in RINSE
        start = 1'b1; row(FILL, 0, 0, 0);
        start = 1'b0; water_full = 1'b1; row(HEAT, 0, 0, 0);
        water_full = 1'b0; temp_ok = 1'b1; row(WASH, 0, 0, 0);
        temp_ok = 1'b0; repeat (2) row(WASH, 0, 0, 0);
        pause = 1'b1; repeat (5) row(WASH, 1, 0, 0);
        pause = 1'b0; row(WASH, 0, 0, 0);
        row(DRAIN, 0, 0, 0);
        water_empty = 1'b1; row(RINSE, 0, 0, 0);
        water_empty = 1'b0; cancel = 1'b1; row(DRAIN, 0, 1, 0);
        cancel = 1'b0; water_empty = 1'b1; row(DONE, 0, 1, 0);
        water_empty = 1'b0; door_closed = 1'b0; row(IDLE, 0, 1, 0);
        door_closed = 1'b1; row(IDLE, 0, 1, 0);
        reset = 1'b1; row(IDLE, 0, 0, 0);
        reset = 1'b0;

        // Hold blocks transitions; cancel beats pause; cancel in HEAT; start held through DONE
        start = 1'b1; row(FILL, 0, 0, 0);
        start = 1'b0; pause = 1'b1; row(FILL, 1, 0, 0);
        water_full = 1'b1; row(FILL, 1, 0, 0);
        pause = 1'b0; row(HEAT, 0, 0, 0);
        water_full = 1'b0; door_closed = 1'b0; cancel = 1'b1; row(DRAIN, 1, 1, 0);
        door_closed = 1'b1; water_empty = 1'b1; row(DRAIN, 0, 1, 0);
        cancel = 1'b0; row(DONE, 0, 1, 0);
        water_empty = 1'b0; start = 1'b1; repeat (2) row(DONE, 0, 1, 0);
        door_closed = 1'b0; row(IDLE, 0, 1, 0);
        repeat (2) row(IDLE, 0, 1, 0);
        door_closed = 1'b1; row(FILL, 0, 0, 0);

        // Run to SPIN, ignored cancel in SPIN, then synchronous reset
        start = 1'b0; water_full = 1'b1; row(HEAT, 0, 0, 0);
        water_full = 1'b0; temp_ok = 1'b1; row(WASH, 0, 0, 0);
        temp_ok = 1'b0; repeat (3) row(WASH, 0, 0, 0);
        row(DRAIN, 0, 0, 0);
        water_empty = 1'b1; row(RINSE, 0, 0, 0);
        water_empty = 1'b0; repeat (2) row(RINSE, 0, 0, 0);
        row(SPIN, 0, 0, 0);
        cancel = 1'b1; row(SPIN, 0, 0, 0);
        cancel = 1'b0; reset = 1'b1; row(IDLE, 0, 0, 0);
        reset = 1'b0; row(IDLE, 0, 0, 0);

        // Fill watchdog
        start = 1'b1; row(FILL, 0, 0, 0);
        start = 1'b0;
`ifdef FILL_TIMEOUT_EN
        repeat (7) row(FILL, 0, 0, 0);
        row(DRAIN, 0, 1, 1);
        water_empty = 1'b1; row(DONE, 0, 1, 1);
        water_empty = 1'b0; door_closed = 1'b0; row(IDLE, 0, 1, 1);
        door_closed = 1'b1; start = 1'b1; row(FILL, 0, 0, 0);
        start = 1'b0;
`else
        repeat (10) row(FILL, 0, 0, 0);
        cancel = 1'b1; row(DRAIN, 0, 1, 0);
        cancel = 1'b0;
`endif
        @(negedge clk);
        check("scoreboard drained", 16'(q.size()), 16'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
